// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared types and constants for the 3x3 convolution sequencer.
//   conv2d_ctrl_state_e : sequencer FSM states
//   KERNEL_DIM          : convolution kernel edge length
//   PRIME_ROWS          : lines that must be buffered before the first full window
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN
  } conv2d_ctrl_state_e;

  localparam int KERNEL_DIM = 3;
  localparam int PRIME_ROWS = KERNEL_DIM - 1;

endpackage

// File: rtl/conv2d_raster_cnt.sv
// conv2d_raster_cnt: raster position of the next pixel to be accepted.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   inc_i         : advance one pixel position
//   col_o, row_o  : current column / row
//   last_col_o    : col_o == IMG_W_P-1
//   last_pix_o    : last column of the last row (final pixel of the frame)
// The counters wrap back to (0,0) after the final pixel of a frame.
module conv2d_raster_cnt #(
  parameter int IMG_W_P = 16,
  parameter int IMG_H_P = 16,
  parameter int CNT_W_P = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               inc_i,
  output logic [CNT_W_P-1:0] col_o,
  output logic [CNT_W_P-1:0] row_o,
  output logic               last_col_o,
  output logic               last_pix_o
);

  localparam logic [CNT_W_P-1:0] LAST_COL = CNT_W_P'(IMG_W_P - 1);
  localparam logic [CNT_W_P-1:0] LAST_ROW = CNT_W_P'(IMG_H_P - 1);
  localparam logic [CNT_W_P-1:0] ONE      = CNT_W_P'(1);

  logic [CNT_W_P-1:0] col_q, col_d;
  logic [CNT_W_P-1:0] row_q, row_d;

  assign last_col_o = (col_q == LAST_COL);
  assign last_pix_o = last_col_o && (row_q == LAST_ROW);
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (inc_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_pix_o ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv2d_window_ctrl.sv
// conv2d_window_ctrl: sequencer for the 3x3 streaming convolution datapath.
// Tracks the raster position of accepted pixels, drives the datapath shift
// enable and qualifies windows so only fully-populated interior windows are
// presented as valid, framed with eol/eof and a frame_done pulse.
//   clk_i, rstn_i       : clock, asynchronous active-low reset
//   start_i             : arms a frame when idle, ignored while busy
//   valid_i / ready_o   : upstream pixel handshake
//   shift_en_o          : datapath shift enable (= valid_i & ready_o)
//   valid_o / ready_i   : downstream window handshake
//   row_o, col_o        : window-centre coordinates of the current output
//   eol_o, eof_o        : current output is last of its line / frame
//   busy_o              : a frame is in progress
//   frame_done_o        : one-cycle pulse after the final window is accepted
//   dbg_state_o         : FSM state, for observation
// Optional build macro CONV2D_CTRL_PERF_EN adds:
//   frame_cnt_o[15:0]   : completed frames, wrapping
//   stall_cnt_o[31:0]   : cycles with valid_o & ~ready_i, saturating
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high; valid is never withdrawn and its payload never changes until it is
// taken, independent of ready.
module conv2d_window_ctrl
  import conv2d_pkg::*;
#(
  parameter int IMG_W_P = 16,
  parameter int IMG_H_P = 16,
  parameter int CNT_W_P = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               shift_en_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [CNT_W_P-1:0] row_o,
  output logic [CNT_W_P-1:0] col_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               busy_o,
  output logic               frame_done_o,
`ifdef CONV2D_CTRL_PERF_EN
  output logic [15:0]        frame_cnt_o,
  output logic [31:0]        stall_cnt_o,
`endif
  output logic [1:0]         dbg_state_o
);

  localparam logic [CNT_W_P-1:0] EDGE     = CNT_W_P'(PRIME_ROWS);
  localparam logic [CNT_W_P-1:0] PRIME_LN = CNT_W_P'(PRIME_ROWS - 1);
  localparam logic [CNT_W_P-1:0] ONE      = CNT_W_P'(1);

  conv2d_ctrl_state_e state_q;
  logic               valid_q, eol_q, eof_q, frame_done_q;
  logic [CNT_W_P-1:0] row_q, col_q;

  logic               accept;
  logic               interior;
  logic [CNT_W_P-1:0] cnt_col, cnt_row;
  logic               cnt_last_col, cnt_last_pix;

  conv2d_raster_cnt #(
    .IMG_W_P (IMG_W_P),
    .IMG_H_P (IMG_H_P),
    .CNT_W_P (CNT_W_P)
  ) u_raster_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .inc_i      (accept),
    .col_o      (cnt_col),
    .row_o      (cnt_row),
    .last_col_o (cnt_last_col),
    .last_pix_o (cnt_last_pix)
  );

  // A held window may only be replaced once downstream takes it.
  assign ready_o    = ((state_q == PRIME) || (state_q == STREAM)) && (!valid_q || ready_i);
  assign accept     = valid_i && ready_o;
  assign shift_en_o = accept;

  // The accepted pixel is the bottom-right tap; the window it completes is
  // centred one row up and one column left. Windows with col<2 straddle a
  // line wrap and those with row<2 reach above the frame.
  assign interior = (cnt_row >= EDGE) && (cnt_col >= EDGE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE:   if (start_i) state_q <= PRIME;
        PRIME:  if (accept && (cnt_row == PRIME_LN) && cnt_last_col) state_q <= STREAM;
        STREAM: if (accept && cnt_last_pix) state_q <= DRAIN;
        DRAIN: begin
          if (valid_q && ready_i) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        valid_q <= interior;
        row_q   <= cnt_row - ONE;
        col_q   <= cnt_col - ONE;
        eol_q   <= interior && cnt_last_col;
        eof_q   <= interior && cnt_last_pix;
      end else if (ready_i) begin
        valid_q <= 1'b0;
        eol_q   <= 1'b0;
        eof_q   <= 1'b0;
      end
      // No accept and no ready: everything holds, matching the frozen window.
    end
  end

  assign valid_o      = valid_q;
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign eol_o        = eol_q;
  assign eof_o        = eof_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != IDLE);
  assign dbg_state_o  = state_q;

`ifdef CONV2D_CTRL_PERF_EN
  logic [15:0] frame_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (frame_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (valid_q && !ready_i && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv2d_window_ctrl.sv
module tb_conv2d_window_ctrl;

  localparam int W     = 16;
  localparam int H     = 16;
  localparam int CW    = 16;
  localparam int BEATS = (W - 2) * (H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          start, vin, rdy_in;
  logic          ready_o, shift_en_o, valid_o, eol_o, eof_o, busy_o, frame_done_o;
  logic [CW-1:0] row_o, col_o;
  logic [1:0]    dbg_state;
`ifdef CONV2D_CTRL_PERF_EN
  logic [15:0]   frame_cnt;
  logic [31:0]   stall_cnt;
`endif

  conv2d_window_ctrl #(.IMG_W_P(W), .IMG_H_P(H), .CNT_W_P(CW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .valid_i      (vin),
    .ready_o      (ready_o),
    .shift_en_o   (shift_en_o),
    .valid_o      (valid_o),
    .ready_i      (rdy_in),
    .row_o        (row_o),
    .col_o        (col_o),
    .eol_o        (eol_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
`ifdef CONV2D_CTRL_PERF_EN
    .frame_cnt_o  (frame_cnt),
    .stall_cnt_o  (stall_cnt),
`endif
    .dbg_state_o  (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected beats {row, col, eol, eof} in raster order.
  logic [2*CW+1:0] exp_q[$];
  int      pix_n = 0;          // pixels accepted in the current frame
  int      beats_in_frame = 0;
  int      frames_done = 0;    // frame_done_o pulses seen
  int      model_frames = 0;
  int      stall_cycles = 0;
  bit      m_busy = 0, m_drain = 0, exp_done = 0;
  bit      prev_int = 0, prev_hold = 0;
  logic [CW-1:0] prev_int_row, prev_int_col, prev_row, prev_col;
  logic    prev_eol, prev_eof;

  always @(negedge clk) begin : monitor
    logic [2*CW+1:0] e;
    bit exp_rdy, was_busy;
    int r, c;
    if (!rstn) begin
      check_eq("rst_valid_o", valid_o, 0);
      check_eq("rst_busy_o", busy_o, 0);
      check_eq("rst_ready_o", ready_o, 0);
      check_eq("rst_frame_done_o", frame_done_o, 0);
      check_eq("rst_row_col", {row_o, col_o}, 0);
      check_eq("rst_eol_eof", {eol_o, eof_o}, 0);
      exp_q.delete();
      pix_n = 0; beats_in_frame = 0; model_frames = 0; stall_cycles = 0;
      m_busy = 0; m_drain = 0; exp_done = 0; prev_int = 0; prev_hold = 0;
    end else begin
      // Output register behaviour from the previous cycle's events.
      check_eq("valid_o", valid_o, prev_int | prev_hold);
      if (prev_int) check_eq("latency_row_col", {row_o, col_o}, {prev_int_row, prev_int_col});
      if (prev_hold) begin
        check_eq("hold_row_col", {row_o, col_o}, {prev_row, prev_col});
        check_eq("hold_eol_eof", {eol_o, eof_o}, {prev_eol, prev_eof});
      end
      check_eq("frame_done_o", frame_done_o, exp_done);
      check_eq("busy_o", busy_o, m_busy);
      exp_rdy = m_busy && !m_drain && (!valid_o || rdy_in);
      check_eq("ready_o", ready_o, exp_rdy);
      check_eq("shift_en_o", shift_en_o, vin & ready_o);

      if (frame_done_o) begin
        check_eq("beats_per_frame", beats_in_frame, BEATS);
        beats_in_frame = 0;
        frames_done++;
      end

      if (valid_o && rdy_in) begin
        check_eq("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("beat_row", row_o, e[2*CW+1:CW+2]);
          check_eq("beat_col", col_o, e[CW+1:2]);
          check_eq("beat_eol", eol_o, e[1]);
          check_eq("beat_eof", eof_o, e[0]);
        end
        beats_in_frame++;
      end
      if (valid_o && !rdy_in) stall_cycles++;

      // Advance the model to the next cycle.
      was_busy  = m_busy;
      exp_done  = m_drain && valid_o && rdy_in;
      prev_hold = valid_o && !rdy_in;
      prev_row  = row_o; prev_col = col_o; prev_eol = eol_o; prev_eof = eof_o;
      prev_int  = 0;
      if (vin && exp_rdy) begin
        r = pix_n / W;
        c = pix_n % W;
        if (r >= 2 && c >= 2) begin
          exp_q.push_back({CW'(r - 1), CW'(c - 1), (c == W - 1), (c == W - 1 && r == H - 1)});
          prev_int = 1;
          prev_int_row = CW'(r - 1);
          prev_int_col = CW'(c - 1);
        end
        pix_n++;
        if (pix_n == W * H) begin
          pix_n = 0;
          m_drain = 1;
        end
      end
      if (exp_done) begin
        m_busy = 0; m_drain = 0; model_frames++;
      end
      if (start && !was_busy) m_busy = 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one frame from a start pulse. stall_at/stall_len force ready_i low;
  // busy_start_at issues a start pulse mid-frame; abort_pix>0 returns early.
  task automatic run_frame(input int vpct, input int rpct, input int stall_at, input int stall_len,
                           input int busy_start_at, input int abort_pix);
    int target = frames_done + 1;
    bit aborted = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      vin    = ($urandom_range(99) < vpct);
      rdy_in = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : ($urandom_range(99) < rpct);
      start  = (cyc == 0) || (cyc == busy_start_at);
      @(posedge clk); #1;
      if (frames_done >= target) break;
      if (abort_pix > 0 && pix_n >= abort_pix) begin
        aborted = 1;
        break;
      end
    end
    start = 0; vin = 0; rdy_in = 1;
    if (abort_pix > 0) check_eq("abort_reached", aborted, 1);
    else check_eq("frame_completed", frames_done >= target, 1);
  endtask

  task automatic idle_cycles(input int n);
    start = 0; vin = 0; rdy_in = 1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 0;
    #1;
    check_eq("async_rst_valid_o", valid_o, 0);
    check_eq("async_rst_busy_o", busy_o, 0);
    check_eq("async_rst_ready_o", ready_o, 0);
    check_eq("async_rst_row_col", {row_o, col_o}, 0);
    check_eq("async_rst_eol_eof", {eol_o, eof_o}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  // ---------------- test sequence ----------------
  int fd_before;
  initial begin
    rstn = 0; start = 0; vin = 0; rdy_in = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    idle_cycles(2);

    // Full-rate frame.
    run_frame(100, 100, -1, 0, -1, 0);
    idle_cycles(3);
    // Downstream stall of 5 cycles in the middle of the stream.
    run_frame(100, 100, 60, 5, -1, 0);
    idle_cycles(3);
    // Random back-pressure over three frames.
    for (int f = 0; f < 3; f++) begin
      run_frame(50, 50, -1, 0, -1, 0);
      idle_cycles(2);
    end
    // Mid-frame start is ignored; reset after 100 pixels discards the frame.
    fd_before = frames_done;
    run_frame(70, 70, -1, 0, 40, 100);
    do_reset();
    idle_cycles(3);
    check_eq("no_done_after_abort", frames_done, fd_before);
    run_frame(100, 100, -1, 0, -1, 0);
    idle_cycles(3);
    // Two frames with a 7-cycle stall from a fresh reset.
    do_reset();
    idle_cycles(2);
    run_frame(100, 100, 60, 7, -1, 0);
    idle_cycles(2);
    run_frame(100, 100, -1, 0, -1, 0);
    idle_cycles(4);
    check_eq("frames_since_reset", model_frames, 2);
    check_eq("stalls_since_reset", stall_cycles, 7);
`ifdef CONV2D_CTRL_PERF_EN
    check_eq("frame_cnt_o", frame_cnt, 2);
    check_eq("stall_cnt_o", stall_cnt, 7);
`endif
    check_eq("queue_empty_at_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
